// File: rtl/uart_tx_device.sv
// -----------------------------------------------------------------------------
// uart_tx_device
// Buffered serial transmitter on the CPU device bus. Writes to offset 1 push a
// byte into a TX FIFO; a bit-timed FSM sends the bytes on tx as 8N1 frames, or
// as 8E1 frames when parity is enabled. There is a registered read port with a
// 1-cycle latency.
//
// Register map (word offset = address[1:0]):
//   0 : device ID (RO)
//   1 : TX data, data_in[7:0] (WO)
//   2 : status (RO; reading it clears overflow)
//   3 : bit divisor (RW; 0 behaves as 1)
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, each frame carries an even-parity bit after the data bits.
//   Status bit [4] reads 1 in this build.
//
// Ports:
//   clock        in   CPU clock; all state changes on the rising edge
//   reset        in   asynchronous reset, active low
//   write_enable in   bus write strobe
//   address      in   16-bit bus word address
//   data_in      in   16-bit write data
//   data_out     out  16-bit registered read data (0 when not decoded)
//   tx           out  serial line, idle high
//   busy         out  FSM active or FIFO non-empty
// -----------------------------------------------------------------------------
module uart_tx_device #(
    parameter logic [15:0] BASE_ADDR  = 16'h0010,
    parameter logic [15:0] CLOCK_DIV  = 16'd737,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DEVICE_ID  = 16'h0002
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [15:0] r_dataOut;
    logic [15:0] r_divisor;
    logic [15:0] r_bitDiv;
    logic [15:0] r_timer;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitIdx;
    logic        r_parity;
    logic        r_overflow;
    logic        r_tx;

    logic [AW:0] w_count;
    logic [8:0]  w_countWide;
    logic [4:0]  w_countField;
    logic        w_empty;
    logic        w_full;
    logic        w_hit;
    logic [1:0]  w_offset;
    logic        w_wrData;
    logic        w_push;
    logic        w_pop;
    logic        w_rdStatus;
    logic [15:0] w_divEff;
    logic [7:0]  w_popData;
    logic [15:0] w_status;

    // The pointers carry an extra MSB, so full and empty differ even though both
    // have equal low pointer bits.
    assign w_count      = r_wrPtr - r_rdPtr;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_countWide  = 9'(w_count);
    assign w_countField = (w_countWide > 9'd31) ? 5'd31 : w_countWide[4:0];

    assign w_hit      = (address[15:2] == BASE_ADDR[15:2]);
    assign w_offset   = address[1:0];
    assign w_wrData   = write_enable && w_hit && (w_offset == 2'd1);
    assign w_push     = w_wrData && !w_full;
    assign w_rdStatus = !write_enable && w_hit && (w_offset == 2'd2);

    // A byte leaves the FIFO when the FSM is idle, or when a stop bit ends and
    // more data is waiting. In that case the next frame follows without a gap.
    assign w_pop     = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_timer == '0)));
    assign w_divEff  = (r_divisor == '0) ? 16'd1 : r_divisor;
    assign w_popData = r_fifo[r_rdPtr[AW-1:0]];

    assign w_status = {3'b000, w_countField, 3'b000, PARITY_PRESENT,
                       r_overflow, w_full, w_empty, busy};

    assign data_out = r_dataOut;
    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

    // FIFO storage has no reset. A reset clears the pointers, and that discards
    // the contents.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wrPtr[AW-1:0]] <= data_in[7:0];
        end
    end

    // Bus side: registered read data, divisor register, write pointer and the
    // sticky overflow flag. A status read captures overflow before clearing it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dataOut  <= '0;
            r_divisor  <= CLOCK_DIV;
            r_overflow <= 1'b0;
            r_wrPtr    <= '0;
        end else begin
            r_dataOut <= '0;
            if (!write_enable && w_hit) begin
                case (w_offset)
                    2'd0:    r_dataOut <= DEVICE_ID;
                    2'd2:    r_dataOut <= w_status;
                    2'd3:    r_dataOut <= r_divisor;
                    default: r_dataOut <= '0;
                endcase
            end
            if (write_enable && w_hit && (w_offset == 2'd3)) begin
                r_divisor <= data_in;
            end
            if (w_wrData && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_rdStatus) begin
                r_overflow <= 1'b0;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
        end
    end

    // Serializer. The divisor is latched only when a frame starts, so a divisor
    // write never changes the bit time of the frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rdPtr  <= '0;
            r_bitDiv <= 16'd1;
            r_timer  <= '0;
            r_shift  <= '0;
            r_bitIdx <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else if (w_pop) begin
            r_rdPtr  <= r_rdPtr + 1'b1;
            r_shift  <= w_popData;
            r_parity <= ^w_popData;
            r_bitDiv <= w_divEff;
            r_timer  <= w_divEff - 16'd1;
            r_tx     <= 1'b0;
            r_state  <= ST_START;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                ST_START: begin
                    if (r_timer == '0) begin
                        r_timer  <= r_bitDiv - 16'd1;
                        r_tx     <= r_shift[0];
                        r_bitIdx <= '0;
                        r_state  <= ST_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == '0) begin
                        r_timer <= r_bitDiv - 16'd1;
                        if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (r_timer == '0) begin
                        r_timer <= r_bitDiv - 16'd1;
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
